// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg
// Shared definitions for the WS2812B frame path: word width, GRB channel
// offsets, the frame scheduler state encoding and the channel scaling
// arithmetic used when global brightness is enabled.
package ws2812b_pkg;

  localparam int WS2812B_WORD_W = 24;

  // Bit offsets of each colour channel inside a GRB word.
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_DRAIN
  } ws2812b_sched_state_t;

  // Scale one channel by (level+1)/256, so level 255 leaves the channel
  // untouched and level 0 still lets a dim channel round down to zero.
  function automatic logic [7:0] scale_channel(input logic [7:0] channel,
                                               input logic [7:0] level);
    logic [16:0] prod;
    prod = {9'd0, channel} * ({9'd0, level} + 17'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/ws2812b_channel_scale.sv
// ws2812b_channel_scale
// One-cycle registered 8x8 brightness scaler for a single colour channel.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   channel - raw 8-bit channel value
//   level   - global brightness level
//   scaled  - (channel*(level+1))>>8, one cycle after the inputs
module ws2812b_channel_scale
  import ws2812b_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] channel,
  input  logic [7:0] level,
  output logic [7:0] scaled
);

  // The scaler runs every cycle; the scheduler decides when the result
  // is meaningful by delaying its own read strobe to line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      scaled <= '0;
    end else begin
      scaled <= scale_channel(channel, level);
    end
  end

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// ws2812b_frame_scheduler
// Walks the pixel store once per frame_tick, fetching one GRB word at a
// time and handing it to the bit serialiser. While a word is on offer the
// next one is prefetched into a staging register, so the serialiser sees a
// single idle cycle between words.
// Optional feature macro: WS2812B_BRIGHTNESS_EN adds the brightness input
// and a registered per-channel scaler in the fetch path (+1 cycle latency).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   frame_tick            - start-of-frame strobe
//   pix_rd, pix_addr      - pixel store read strobe and index
//   pix_data              - GRB word, valid the cycle after pix_rd
//   bitstream_available   - bitstream holds an unconsumed word
//   bitstream             - word for the serialiser
//   bitstream_read        - serialiser consumed the word
//   brightness            - global level (WS2812B_BRIGHTNESS_EN only)
//   busy                  - frame in progress
//   frame_done            - pulse after the last word is taken
//   tick_missed           - pulse when a frame_tick is ignored
module ws2812b_frame_scheduler
  import ws2812b_pkg::*;
#(
  parameter int LEDCOUNT = 36,
  parameter int AW       = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  output logic                      pix_rd,
  output logic [AW-1:0]             pix_addr,
  input  logic [WS2812B_WORD_W-1:0] pix_data,
  output logic                      bitstream_available,
  output logic [WS2812B_WORD_W-1:0] bitstream,
  input  logic                      bitstream_read,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0]                brightness,
`endif
  output logic                      busy,
  output logic                      frame_done,
  output logic                      tick_missed
);

  localparam logic [AW-1:0] LAST_IDX = AW'(LEDCOUNT - 1);

  ws2812b_sched_state_t state;

  logic [AW-1:0]             fetch_idx;
  logic                      inflight;
  logic                      rd_d1;
  logic [WS2812B_WORD_W-1:0] staged;
  logic                      staged_valid;
  logic                      staged_last;
  logic                      word_last;
  logic                      present_next;

  logic                      cap_valid;
  logic [WS2812B_WORD_W-1:0] cap_data;
  logic                      cap_is_last;
  logic                      take;
  logic                      cap_to_bs;
  logic                      cap_to_stage;
  logic                      stage_to_bs;
  logic                      issue;

`ifdef WS2812B_BRIGHTNESS_EN
  logic       rd_d2;
  logic [7:0] scaled_g;
  logic [7:0] scaled_r;
  logic [7:0] scaled_b;

  ws2812b_channel_scale u_scale_g (
    .clk     (clk),
    .reset   (reset),
    .channel (pix_data[G_LSB +: 8]),
    .level   (brightness),
    .scaled  (scaled_g)
  );

  ws2812b_channel_scale u_scale_r (
    .clk     (clk),
    .reset   (reset),
    .channel (pix_data[R_LSB +: 8]),
    .level   (brightness),
    .scaled  (scaled_r)
  );

  ws2812b_channel_scale u_scale_b (
    .clk     (clk),
    .reset   (reset),
    .channel (pix_data[B_LSB +: 8]),
    .level   (brightness),
    .scaled  (scaled_b)
  );

  assign cap_valid = rd_d2;
  assign cap_data  = {scaled_g, scaled_r, scaled_b};

  // Read strobe delay line: the scaled word appears two cycles after pix_rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1 <= 1'b0;
      rd_d2 <= 1'b0;
    end else begin
      rd_d1 <= pix_rd;
      rd_d2 <= rd_d1;
    end
  end
`else
  assign cap_valid = rd_d1;
  assign cap_data  = pix_data;

  // Read strobe delay line: the store answers one cycle after pix_rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1 <= 1'b0;
    end else begin
      rd_d1 <= pix_rd;
    end
  end
`endif

  assign take        = bitstream_read && bitstream_available;
  // Only one read is ever in flight, so the arriving word is the one at
  // fetch_idx even if a new read is issued on the same edge.
  assign cap_is_last = (fetch_idx == LAST_IDX);

  // Routing of the fetched word. A word goes straight into bitstream when
  // the serialiser is waiting for it (first word, or the consumed word had
  // nothing staged behind it); otherwise it parks in the staging register.
  // A new prefetch is issued as soon as both the staging register and the
  // read path will be free after this edge, which keeps the inter-word gap
  // at one cycle even when the serialiser reads back-to-back.
  always_comb begin
    stage_to_bs  = 1'b0;
    cap_to_bs    = 1'b0;
    cap_to_stage = 1'b0;
    issue        = 1'b0;

    stage_to_bs = (state == ST_PRESENT) && take && !word_last && staged_valid;

    if (cap_valid) begin
      if (state == ST_FETCH) begin
        cap_to_bs = 1'b1;
      end else if (state == ST_PRESENT) begin
        cap_to_bs = (take && !word_last && !staged_valid) ||
                    (!bitstream_available && !present_next);
        cap_to_stage = !cap_to_bs;
      end
    end

    issue = ((state == ST_FETCH) || (state == ST_PRESENT)) &&
            (fetch_idx != LAST_IDX) &&
            (!inflight || cap_valid) &&
            (!staged_valid || stage_to_bs) &&
            !cap_to_stage;
  end

  // Frame sequencer with registered outputs. Datapath moves (prefetch,
  // staging, bitstream load) are applied first; the state case then sets
  // the handshake flags. A word loaded on a consuming edge is held back
  // for one cycle (present_next) so the serialiser sees available drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      fetch_idx           <= '0;
      inflight            <= 1'b0;
      staged              <= '0;
      staged_valid        <= 1'b0;
      staged_last         <= 1'b0;
      word_last           <= 1'b0;
      present_next        <= 1'b0;
      pix_rd              <= 1'b0;
      pix_addr            <= '0;
      bitstream           <= '0;
      bitstream_available <= 1'b0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
      tick_missed         <= 1'b0;
    end else begin
      pix_rd      <= 1'b0;
      frame_done  <= 1'b0;
      tick_missed <= frame_tick && (state != ST_IDLE);

      if (cap_valid) begin
        inflight <= 1'b0;
      end

      if (issue) begin
        pix_rd    <= 1'b1;
        pix_addr  <= fetch_idx + 1'b1;
        fetch_idx <= fetch_idx + 1'b1;
        inflight  <= 1'b1;
      end

      if (cap_to_stage) begin
        staged       <= cap_data;
        staged_valid <= 1'b1;
        staged_last  <= cap_is_last;
      end

      if (stage_to_bs) begin
        bitstream    <= staged;
        word_last    <= staged_last;
        staged_valid <= 1'b0;
      end

      if (cap_to_bs) begin
        bitstream <= cap_data;
        word_last <= cap_is_last;
      end

      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state        <= ST_FETCH;
            pix_rd       <= 1'b1;
            pix_addr     <= '0;
            fetch_idx    <= '0;
            inflight     <= 1'b1;
            busy         <= 1'b1;
            staged_valid <= 1'b0;
            present_next <= 1'b0;
            word_last    <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (cap_valid) begin
            bitstream_available <= 1'b1;
            state               <= ST_PRESENT;
          end
        end

        ST_PRESENT: begin
          if (take) begin
            bitstream_available <= 1'b0;
            if (word_last) begin
              state      <= ST_DRAIN;
              frame_done <= 1'b1;
            end else if (stage_to_bs || cap_to_bs) begin
              present_next <= 1'b1;
            end
          end else if (present_next) begin
            bitstream_available <= 1'b1;
            present_next        <= 1'b0;
          end else if (cap_to_bs) begin
            bitstream_available <= 1'b1;
          end
        end

        ST_DRAIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
